// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded operands and main-control
// signals, with stall hold, flush bubble insertion and a debug bubble counter.
//
// Ports:
//   clk, reset_n        core clock (rising edge), async active-low reset
//   stall, flush        hazard controls; flush has priority over stall
//   id_*                decoded instruction fields from ID
//   ex_*                registered copies presented to EX
//   ex_inst_function    registered id_imm_ext[5:0], function field for Alu_control
//   ex_valid            EX holds a real instruction
//   bubble_count        saturating count of flush-inserted bubbles
module id_ex_stage #(
    parameter int data_width          = 32,
    parameter int reg_addr_width      = 5,
    parameter int control_aluop_width = 3,
    parameter int bubble_count_width  = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           stall,
    input  logic                           flush,
    input  logic                           id_valid,
    input  logic [data_width-1:0]          id_pc_next,
    input  logic [data_width-1:0]          id_rs_data,
    input  logic [data_width-1:0]          id_rt_data,
    input  logic [data_width-1:0]          id_imm_ext,
    input  logic [reg_addr_width-1:0]      id_rs,
    input  logic [reg_addr_width-1:0]      id_rt,
    input  logic [reg_addr_width-1:0]      id_rd,
    input  logic [4:0]                     id_shamt,
    input  logic [control_aluop_width-1:0] id_control_aluop,
    input  logic                           id_alu_src,
    input  logic                           id_reg_dst,
    input  logic                           id_mem_read,
    input  logic                           id_mem_write,
    input  logic                           id_reg_write,
    input  logic                           id_mem_to_reg,
    input  logic                           id_branch,
    output logic [data_width-1:0]          ex_pc_next,
    output logic [data_width-1:0]          ex_rs_data,
    output logic [data_width-1:0]          ex_rt_data,
    output logic [data_width-1:0]          ex_imm_ext,
    output logic [reg_addr_width-1:0]      ex_rs,
    output logic [reg_addr_width-1:0]      ex_rt,
    output logic [reg_addr_width-1:0]      ex_rd,
    output logic [4:0]                     ex_shamt,
    output logic [control_aluop_width-1:0] ex_control_aluop,
    output logic                           ex_alu_src,
    output logic                           ex_reg_dst,
    output logic                           ex_mem_read,
    output logic                           ex_mem_write,
    output logic                           ex_reg_write,
    output logic                           ex_mem_to_reg,
    output logic                           ex_branch,
    output logic [5:0]                     ex_inst_function,
    output logic                           ex_valid,
    output logic [bubble_count_width-1:0]  bubble_count
);

    localparam logic [bubble_count_width-1:0] bc_one =
        {{(bubble_count_width-1){1'b0}}, 1'b1};

    logic bc_sat;
    assign bc_sat = &bubble_count;

    // A bubble is the same all-zero state as reset: RTYPE aluop with
    // function SLL on $0, i.e. a NOP with every side effect disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_pc_next       <= '0;
            ex_rs_data       <= '0;
            ex_rt_data       <= '0;
            ex_imm_ext       <= '0;
            ex_rs            <= '0;
            ex_rt            <= '0;
            ex_rd            <= '0;
            ex_shamt         <= '0;
            ex_control_aluop <= '0;
            ex_alu_src       <= 1'b0;
            ex_reg_dst       <= 1'b0;
            ex_mem_read      <= 1'b0;
            ex_mem_write     <= 1'b0;
            ex_reg_write     <= 1'b0;
            ex_mem_to_reg    <= 1'b0;
            ex_branch        <= 1'b0;
            ex_inst_function <= '0;
            ex_valid         <= 1'b0;
            bubble_count     <= '0;
        end else if (flush) begin
            ex_pc_next       <= '0;
            ex_rs_data       <= '0;
            ex_rt_data       <= '0;
            ex_imm_ext       <= '0;
            ex_rs            <= '0;
            ex_rt            <= '0;
            ex_rd            <= '0;
            ex_shamt         <= '0;
            ex_control_aluop <= '0;
            ex_alu_src       <= 1'b0;
            ex_reg_dst       <= 1'b0;
            ex_mem_read      <= 1'b0;
            ex_mem_write     <= 1'b0;
            ex_reg_write     <= 1'b0;
            ex_mem_to_reg    <= 1'b0;
            ex_branch        <= 1'b0;
            ex_inst_function <= '0;
            ex_valid         <= 1'b0;
            if (!bc_sat) begin
                bubble_count <= bubble_count + bc_one;
            end
        end else if (!stall) begin
            ex_pc_next       <= id_pc_next;
            ex_rs_data       <= id_rs_data;
            ex_rt_data       <= id_rt_data;
            ex_imm_ext       <= id_imm_ext;
            ex_rs            <= id_rs;
            ex_rt            <= id_rt;
            ex_rd            <= id_rd;
            ex_shamt         <= id_shamt;
            ex_control_aluop <= id_control_aluop;
            ex_alu_src       <= id_alu_src;
            ex_reg_dst       <= id_reg_dst;
            ex_mem_read      <= id_mem_read;
            ex_mem_write     <= id_mem_write;
            ex_reg_write     <= id_reg_write;
            ex_mem_to_reg    <= id_mem_to_reg;
            ex_branch        <= id_branch;
            ex_inst_function <= id_imm_ext[5:0];
            // Invalid instructions still load; EX gates on ex_valid.
            ex_valid         <= id_valid;
        end
    end

endmodule
